apb_spi_fifo_regs: RTL and testbench

Parametrised successor to the single-word APB/SPI register front end. APB slave with TX and RX FIFOs, a configurable slave-select count, a launch sequencer that issues one start_op per queued word (auto-repeat optional), sticky error flags and a maskable interrupt. Sits between the APB bus and the SPI master core.

---
 rtl/apb_spi_pkg.sv | 31 +++
 rtl/spi_sync_fifo.sv | 43 ++++
 rtl/apb_spi_fifo_regs.sv | 160 ++++++++++++++++
 tb/tb_apb_spi_fifo_regs.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg: register map, bit positions and state encodings shared by the APB/SPI FIFO front end.
package apb_spi_pkg;

    localparam logic [7:0] REG_TXDATA = 8'h00;
    localparam logic [7:0] REG_RXDATA = 8'h04;
    localparam logic [7:0] REG_CFG    = 8'h08;
    localparam logic [7:0] REG_CTRL   = 8'h0C;
    localparam logic [7:0] REG_STT    = 8'h10;
    localparam logic [7:0] REG_IRQEN  = 8'h14;

    localparam int CFG_CPOL  = 0;
    localparam int CFG_CPHA  = 1;
    localparam int CFG_ORDER = 2;
    localparam int CFG_SCKS  = 3;

    localparam int CTRL_RD    = 8;
    localparam int CTRL_START = 9;
    localparam int CTRL_AUTO  = 10;

    localparam int STT_BUSY     = 0;
    localparam int STT_TX_OVF   = 5;
    localparam int STT_TIMEOUT  = 8;
    localparam int STT_TX_LEVEL = 16;
    localparam int STT_RX_LEVEL = 24;

    localparam logic [4:0] TIMEOUT_LIMIT = 5'd15;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO} seq_state_e;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous FIFO with simultaneous push/pop; a push into a full FIFO lands only alongside a real pop.
module spi_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok, push_ok;

    assign level_o = wr_q - rd_q;
    assign empty_o = wr_q == rd_q;
    assign full_o  = level_o[AW];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(push_ok);
            rd_q <= rd_q + (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/apb_spi_fifo_regs.sv
// apb_spi_fifo_regs: APB slave with TX/RX FIFOs, launch sequencer, sticky flags and irq for an SPI master.
// Define APB_SPI_BUSY_TIMEOUT_EN to abandon a launch whose busy never rises within 16 cycles.
module apb_spi_fifo_regs
    import apb_spi_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_SS     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              ctrl_cpol,
    output logic              ctrl_cpha,
    output logic              ctrl_order,
    output logic [1:0]        ctrl_scks,
    output logic [NUM_SS-1:0] ctrl_slave_en,
    output logic              ctrl_rd,
    output logic              start_op,
    input  logic              busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    apb_state_e        apb_q, apb_d;
    seq_state_e        seq_q, seq_d;
    logic [4:0]        cfg_q, cfg_d;
    logic [NUM_SS-1:0] slv_q, slv_d;
    logic              rd_q, rd_d, auto_q, auto_d, irq_q, irq_d;
    logic [2:0]        ien_q, ien_d;
    logic [3:0]        flg_q, flg_d, flg_set, flg_clr;
    logic [ADDR_W-1:0] wa;
    logic              acc, wr, rd_acc, locked, start, tmo_hit;
    logic              hit_tx, hit_rx, hit_cfg, hit_ctrl, hit_stt, hit_ien, hit_any;
    logic              tx_pop, tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [LW-1:0]     tx_lvl, rx_lvl;
    logic [31:0]       stt;

    assign acc      = apb_q == A_ACCESS;
    assign wr       = acc && pwrite;
    assign rd_acc   = acc && !pwrite;
    assign wa       = paddr & ~ADDR_W'(3);
    assign hit_tx   = wa == ADDR_W'(REG_TXDATA);
    assign hit_rx   = wa == ADDR_W'(REG_RXDATA);
    assign hit_cfg  = wa == ADDR_W'(REG_CFG);
    assign hit_ctrl = wa == ADDR_W'(REG_CTRL);
    assign hit_stt  = wa == ADDR_W'(REG_STT);
    assign hit_ien  = wa == ADDR_W'(REG_IRQEN);
    assign hit_any  = hit_tx || hit_rx || hit_cfg || hit_ctrl || hit_stt || hit_ien;
    assign locked   = seq_q != S_IDLE;
    assign start    = wr && hit_ctrl && !locked && pwdata[CTRL_START];
    assign tx_pop   = seq_q == S_LAUNCH;

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push_i(wr && hit_tx), .data_i(pwdata[DATA_W-1:0]), .pop_i(tx_pop),
        .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_lvl)
    );

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push_i(rx_valid), .data_i(rx_data), .pop_i(rd_acc && hit_rx),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_lvl)
    );

`ifdef APB_SPI_BUSY_TIMEOUT_EN
    logic [4:0] tmo_q, tmo_d;
    assign tmo_hit = seq_q == S_WAIT_HI && !busy && tmo_q == TIMEOUT_LIMIT;
    assign tmo_d   = (seq_q == S_WAIT_HI && !busy) ? tmo_q + 5'd1 : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign apb_d = (apb_q == A_IDLE)  ? ((psel && !penable) ? A_SETUP : A_IDLE) :
                   (apb_q == A_SETUP) ? (!psel ? A_IDLE : penable ? A_ACCESS : A_SETUP) : A_IDLE;

    always_comb begin
        seq_d = seq_q;
        unique case (seq_q)
            S_IDLE:    seq_d = (start && (!tx_empty || pwdata[CTRL_RD])) ? S_LAUNCH : S_IDLE;
            S_LAUNCH:  seq_d = S_WAIT_HI;
            S_WAIT_HI: seq_d = busy ? S_WAIT_LO : tmo_hit ? S_IDLE : S_WAIT_HI;
            S_WAIT_LO: seq_d = busy ? S_WAIT_LO : (auto_q && !tx_empty) ? S_LAUNCH : S_IDLE;
            default:   seq_d = S_IDLE;
        endcase
    end

    // A full TX push only lands if the sequencer pops in the same cycle.
    assign flg_set = {tmo_hit, rd_acc && hit_rx && rx_empty,
                      rx_valid && rx_full && !(rd_acc && hit_rx), wr && hit_tx && tx_full && !tx_pop};
    assign flg_clr = (wr && hit_stt) ? pwdata[STT_TIMEOUT:STT_TX_OVF] : '0;
    assign flg_d   = (flg_q & ~flg_clr) | flg_set;
    assign cfg_d   = (wr && hit_cfg && !locked) ? pwdata[4:0] : cfg_q;
    assign slv_d   = (wr && hit_ctrl && !locked) ? pwdata[NUM_SS-1:0] : slv_q;
    assign rd_d    = (wr && hit_ctrl && !locked) ? pwdata[CTRL_RD] : rd_q;
    assign auto_d  = (wr && hit_ctrl && !locked) ? pwdata[CTRL_AUTO] : auto_q;
    assign ien_d   = (wr && hit_ien) ? pwdata[2:0] : ien_q;
    assign irq_d   = |(ien_q & {|flg_q, !rx_empty, tx_empty});

    assign stt = {8'(rx_lvl), 8'(tx_lvl), 7'd0, flg_q, rx_empty, rx_full, tx_empty, tx_full, busy || locked};

    assign pready  = acc;
    assign pslverr = acc && ((hit_tx && pwrite && tx_full && !tx_pop) || (hit_rx && (pwrite || rx_empty)) ||
                             ((hit_cfg || hit_ctrl) && pwrite && locked) || !hit_any);
    assign prdata  = !rd_acc ? '0 :
                     hit_rx   ? (rx_empty ? '0 : 32'(rx_head)) :
                     hit_cfg  ? 32'(cfg_q) :
                     hit_ctrl ? 32'({auto_q, 1'b0, rd_q, 8'(slv_q)}) :
                     hit_stt  ? stt :
                     hit_ien  ? 32'(ien_q) : '0;

    assign tx_data       = tx_empty ? '0 : tx_head;
    assign ctrl_cpol     = cfg_q[CFG_CPOL];
    assign ctrl_cpha     = cfg_q[CFG_CPHA];
    assign ctrl_order    = cfg_q[CFG_ORDER];
    assign ctrl_scks     = cfg_q[CFG_SCKS+1:CFG_SCKS];
    assign ctrl_slave_en = slv_q;
    assign ctrl_rd       = rd_q;
    assign start_op      = seq_q == S_LAUNCH;
    assign irq           = irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_q  <= A_IDLE;
            seq_q  <= S_IDLE;
            cfg_q  <= '0;
            slv_q  <= '0;
            rd_q   <= 1'b0;
            auto_q <= 1'b0;
            ien_q  <= '0;
            flg_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            apb_q  <= apb_d;
            seq_q  <= seq_d;
            cfg_q  <= cfg_d;
            slv_q  <= slv_d;
            rd_q   <= rd_d;
            auto_q <= auto_d;
            ien_q  <= ien_d;
            flg_q  <= flg_d;
            irq_q  <= irq_d;
        end
    end

endmodule

// File: tb/tb_apb_spi_fifo_regs.sv
// tb_apb_spi_fifo_regs: directed APB/SPI traffic; a monitor scores every pready and start_op against queued expectations.
module tb_apb_spi_fifo_regs;
    logic        clk = 1'b0, rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0, prdata, tx_data, rx_data = '0;
    logic        pready, pslverr, ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd, start_op, irq;
    logic [1:0]  ctrl_scks;
    logic [3:0]  ctrl_slave_en;
    logic        busy = 1'b0, rx_valid = 1'b0;
    int          total = 0, bad = 0;

    typedef struct { string name; logic [31:0] data; logic err; } apb_exp_t;
    apb_exp_t    aq[$];
    logic [31:0] lq[$];

    apb_spi_fifo_regs dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr), .tx_data(tx_data),
        .ctrl_cpol(ctrl_cpol), .ctrl_cpha(ctrl_cpha), .ctrl_order(ctrl_order), .ctrl_scks(ctrl_scks),
        .ctrl_slave_en(ctrl_slave_en), .ctrl_rd(ctrl_rd), .start_op(start_op), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apb(input string nm, input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee);
        int n = 0;
        aq.push_back('{nm, ed, ee});
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        do begin @(posedge clk); #1 n++; end while (!pready && n < 8);
        if (!pready) begin
            total++; bad++;
            $display("FAIL %s_timeout: pready=0 want 1", nm);
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_launch(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!start_op && n < 20);
        chk({nm, "_seen"}, 32'(start_op), 1);
    endtask

    task automatic xfer(input int hold);
        @(posedge clk); #1 busy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input logic [31:0] v);
        rx_valid = 1'b1; rx_data = v;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    initial begin
        apb_exp_t e;
        logic [31:0] t;
        forever begin
            @(negedge clk);
            if (pready) begin
                if (aq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL apb_extra: got unexpected pready want none");
                end else begin
                    e = aq.pop_front();
                    chk({e.name, "_data"}, prdata, e.data);
                    chk({e.name, "_err"}, 32'(pslverr), 32'(e.err));
                end
            end
            if (start_op) begin
                if (lq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL launch_extra: got start_op tx_data=%h want none", tx_data);
                end else begin
                    t = lq.pop_front();
                    chk("launch_tx_data", tx_data, t);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", 32'(pready), 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_start", 32'(start_op), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ctrl", 32'({ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_scks, ctrl_rd, ctrl_slave_en}), 0);
        chk("rst_txdata", tx_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        apb("w_a5", 1, 8'h00, 32'hA5, 0, 0);
        apb("w_33", 1, 8'h00, 32'h33, 0, 0);
        apb("stt1", 0, 8'h10, 0, 32'h0002_0010, 0);

        apb("w_cfg", 1, 8'h08, 32'h1F, 0, 0);
        chk("cfg_out", 32'({ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_scks}), 32'h1F);
        apb("r_cfg", 0, 8'h08, 0, 32'h1F, 0);
        lq.push_back(32'hA5);
        apb("w_start1", 1, 8'h0C, 32'h201, 0, 0);
        wait_launch("launch1");
        xfer(2);
        chk("slave_en", 32'(ctrl_slave_en), 1);
        apb("stt2", 0, 8'h10, 0, 32'h0001_0010, 0);
        lq.push_back(32'h33);
        apb("w_auto", 1, 8'h0C, 32'h601, 0, 0);
        wait_launch("launch2");
        xfer(2);
        apb("r_ctrl", 0, 8'h0C, 0, 32'h401, 0);
        apb("stt3", 0, 8'h10, 0, 32'h0000_0014, 0);
        apb("w_discard", 1, 8'h0C, 32'h201, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        lq.push_back(32'h0);
        apb("w_dummy", 1, 8'h0C, 32'h301, 0, 0);
        wait_launch("launch_dummy");
        xfer(1);
        chk("ctrl_rd", 32'(ctrl_rd), 1);

        for (int i = 1; i <= 8; i++) apb("push", 1, 8'h00, 32'h100 + 32'(i), 0, 0);
        apb("push_full", 1, 8'h00, 32'h109, 0, 1);
        apb("stt_ovf", 0, 8'h10, 0, 32'h0008_0032, 0);
        apb("w1c_txovf", 1, 8'h10, 32'h20, 0, 0);
        apb("stt_clr", 0, 8'h10, 0, 32'h0008_0012, 0);

        lq.push_back(32'h101);
        apb("w_start3", 1, 8'h0C, 32'h201, 0, 0);
        wait_launch("launch3");
        @(posedge clk); #1 busy = 1'b1;
        @(posedge clk); #1;
        apb("w_cfg_lock", 1, 8'h08, 32'h0, 0, 1);
        apb("w_ctrl_lock", 1, 8'h0C, 32'h201, 0, 1);
        apb("stt_busy", 0, 8'h10, 0, 32'h0007_0011, 0);
        chk("cpol_kept", 32'(ctrl_cpol), 1);
        busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apb("w_bad", 1, 8'hFF, 32'hFFFF_FFFF, 0, 1);
        apb("r_bad", 0, 8'hFF, 0, 0, 1);

        apb("r_rx_empty", 0, 8'h04, 0, 0, 1);
        apb("stt_udf", 0, 8'h10, 0, 32'h0007_0090, 0);
        apb("w_ien", 1, 8'h14, 32'h2, 0, 0);
        chk("irq_idle", 32'(irq), 0);
        rx_push(32'hAABB_CCDD);
        chk("irq_early", 32'(irq), 0);
        @(posedge clk); #1;
        chk("irq_late", 32'(irq), 1);
        apb("r_rx", 0, 8'h04, 0, 32'hAABB_CCDD, 0);
        apb("w_rx", 1, 8'h04, 32'h1, 0, 1);
        apb("w1c_all", 1, 8'h10, 32'h1E0, 0, 0);
        for (int i = 0; i < 9; i++) rx_push(32'h10 + 32'(i));
        apb("stt_rxovf", 0, 8'h10, 0, 32'h0807_0048, 0);
        apb("r_rx_first", 0, 8'h04, 0, 32'h10, 0);
        chk("irq_rx", 32'(irq), 1);

        lq.push_back(32'h102);
        apb("w_start4", 1, 8'h0C, 32'h201, 0, 0);
        wait_launch("launch4");
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_start", 32'(start_op), 0);
        chk("rst_mid_irq", 32'(irq), 0);
        chk("rst_mid_slv", 32'(ctrl_slave_en), 0);
        chk("rst_mid_cpol", 32'(ctrl_cpol), 0);
        chk("rst_mid_txdata", tx_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        apb("stt_rst", 0, 8'h10, 0, 32'h0000_0014, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_after_rst", 32'(irq), 0);
        chk("apb_queue_left", 32'(aq.size()), 0);
        chk("launch_queue_left", 32'(lq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
